// File: rtl/multipath_spy_monitor_pkg.sv
// multipath_spy_monitor_pkg: shared FSM state enum, spy-chain stage-type constants and expected-parity helper
package multipath_spy_monitor_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, SETTLE, CAPTURE, DONE} state_t;
  localparam logic STG_BUF = 1'b0;
  localparam logic STG_INV = 1'b1;
  function automatic logic stage_type(input int k);
    return (k % 2 == 0) ? STG_INV : STG_BUF;
  endfunction
  function automatic logic exp_parity(input int depth);
    return ((depth / 2) % 2) != 0;
  endfunction
endpackage

// File: rtl/multipath_spy_monitor_if.sv
// multipath_spy_monitor_if: run bus; master drives start/settle_cycles/meas_count, slave (monitor) returns busy/done/err_cnt/ht_armed
interface multipath_spy_monitor_if #(
  parameter int NUM_PATHS = 4,
  parameter int CNT_W = 16,
  parameter int SET_W = 8,
  parameter int MEAS_W = 16
);
  logic start;
  logic [SET_W-1:0] settle_cycles;
  logic [MEAS_W-1:0] meas_count;
  logic busy;
  logic done;
  logic [NUM_PATHS*CNT_W-1:0] err_cnt;
  logic ht_armed;
  modport master (output start, settle_cycles, meas_count, input busy, done, err_cnt, ht_armed);
  modport slave (input start, settle_cycles, meas_count, output busy, done, err_cnt, ht_armed);
endinterface

// File: rtl/multipath_spy_monitor_chain.sv
// spy_path_chain: DEPTH kept gate stages (NAND(x,1) on even stage numbers, AND(x,1) on odd) from in_bit to out_bit
module spy_path_chain
  import multipath_spy_monitor_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic in_bit,
  output logic out_bit
);
  (* keep = "true" *) logic [DEPTH:0] s;
  assign s[0] = in_bit;
  for (genvar k = 1; k <= DEPTH; k++) begin : g_stg
    if (stage_type(k) == STG_INV) begin : g_nand
      assign s[k] = ~(s[k-1] & 1'b1);
    end else begin : g_and
      assign s[k] = s[k-1] & 1'b1;
    end
  end
  assign out_bit = s[DEPTH];
endmodule

// File: rtl/multipath_spy_monitor.sv
// multipath_spy_monitor: launch/settle/capture harness over NUM_PATHS spy chains with per-path saturating error counters; ports clk, rst (async high), HT_IN1/HT_IN2, bus (slave); SPY_HT_EN builds the event-counting trojan
module multipath_spy_monitor
  import multipath_spy_monitor_pkg::*;
#(
  parameter int NUM_PATHS = 4,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16,
  parameter int SET_W = 8,
  parameter int MEAS_W = 16,
  parameter int HT_THRESH = 8,
  parameter int HT_PATH = 0
) (
  input logic clk,
  input logic rst,
  (* keep = "true" *) input logic HT_IN1,
  (* keep = "true" *) input logic HT_IN2,
  multipath_spy_monitor_if.slave bus
);
  localparam logic PAR = exp_parity(DEPTH);
  state_t state_q, state_d;
  logic [SET_W-1:0] set_q, set_d, cnt_q, cnt_d;
  logic [MEAS_W-1:0] rem_q, rem_d;
  logic launch_q, launch_d, busy_q, busy_d, done_q, done_d, ht_armed_q;
  logic [NUM_PATHS*CNT_W-1:0] err_q, err_d;
  logic [NUM_PATHS-1:0] path_out, cap;
  for (genvar p = 0; p < NUM_PATHS; p++) begin : g_path
    spy_path_chain #(.DEPTH(DEPTH)) u_chain (.in_bit(launch_q), .out_bit(path_out[p]));
  end
  assign cap = path_out ^ (NUM_PATHS'(ht_armed_q) << HT_PATH);
`ifdef SPY_HT_EN
  logic [7:0] ht_cnt_q, ht_cnt_d;
  logic ht_armed_d;
  always_comb begin
    ht_cnt_d = (HT_IN1 && HT_IN2 && ht_cnt_q != 8'(HT_THRESH)) ? ht_cnt_q + 8'd1 : ht_cnt_q;
    ht_armed_d = ht_armed_q | (ht_cnt_d == 8'(HT_THRESH));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ht_cnt_q <= '0;
      ht_armed_q <= 1'b0;
    end else begin
      ht_cnt_q <= ht_cnt_d;
      ht_armed_q <= ht_armed_d;
    end
  end
`else
  logic unused_ht;
  assign unused_ht = HT_IN1 ^ HT_IN2;
  assign ht_armed_q = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    set_d = set_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    launch_d = launch_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (bus.start) begin
        set_d = bus.settle_cycles;
        rem_d = bus.meas_count;
        err_d = '0;
        state_d = (bus.meas_count == '0) ? DONE : LAUNCH;
      end
      LAUNCH: begin
        launch_d = ~launch_q;
        cnt_d = set_q;
        state_d = (set_q == '0) ? CAPTURE : SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q - SET_W'(1);
        state_d = (cnt_q == SET_W'(1)) ? CAPTURE : SETTLE;
      end
      CAPTURE: begin
        for (int p = 0; p < NUM_PATHS; p++)
          if (cap[p] != (launch_q ^ PAR) && err_q[p*CNT_W +: CNT_W] != '1)
            err_d[p*CNT_W +: CNT_W] = err_q[p*CNT_W +: CNT_W] + CNT_W'(1);
        rem_d = rem_q - MEAS_W'(1);
        state_d = (rem_q == MEAS_W'(1)) ? DONE : LAUNCH;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    done_d = state_q == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      set_q <= '0;
      cnt_q <= '0;
      rem_q <= '0;
      launch_q <= 1'b0;
      err_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q <= set_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      launch_q <= launch_d;
      err_q <= err_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err_cnt = err_q;
  assign bus.ht_armed = ht_armed_q;
endmodule
